// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage F/D/E/M/W core.
// Tracks the E/M/W writer history for the forwarding unit and turns load-use,
// data-memory wait, branch redirect and fence conditions into stall, bubble,
// flush and freeze controls.
// Optional feature macro: HAZ_PERF_CNT_EN enables the saturating performance
// counters; without it the counter ports are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int unsigned XLEN_CNT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d_valid,
  input  logic                d_rd_write,
  input  logic [4:0]          d_rd_addr,
  input  logic                d_is_load,
  input  logic                d_fence,
  input  logic                skip_instr,
  input  logic                ex_redirect,
  input  logic                m_mem_req,
  input  logic                dmem_ready,
  output logic                prev1_write,
  output logic                prev2_write,
  output logic                prev3_write,
  output logic [4:0]          prev1_write_addr,
  output logic [4:0]          prev2_write_addr,
  output logic [4:0]          prev3_write_addr,
  output logic                prev1_mem,
  output logic                prev2_mem,
  output logic                prev3_mem,
  output logic                f_stall,
  output logic                d_stall,
  output logic                e_bubble,
  output logic                d_flush,
  output logic                pipe_freeze,
  output logic [XLEN_CNT-1:0] cnt_loaduse,
  output logic [XLEN_CNT-1:0] cnt_memwait,
  output logic [XLEN_CNT-1:0] cnt_flush
);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StDrain
  } state_e;

  typedef struct packed {
    logic       write;
    logic [4:0] addr;
    logic       mem;
  } hist_t;

  state_e          state_q, state_d;
  // Index 0 is E, 1 is M, 2 is W.
  hist_t [2:0]     hist_q, hist_d;
  hist_t           d_entry;
  hist_t           shift_in;
  logic            shift_en;
  logic            any_write;

  // x0 is recorded as a non-writer so it is never forwarded.
  assign d_entry   = '{write: d_valid && d_rd_write && (d_rd_addr != 5'd0),
                       addr:  d_rd_addr,
                       mem:   d_is_load};
  assign any_write = hist_q[0].write | hist_q[1].write | hist_q[2].write;

  // Next-state and control decode; RUN rules are shared with the MEM_WAIT release cycle.
  always_comb begin
    state_d     = state_q;
    shift_en    = 1'b0;
    shift_in    = '0;
    f_stall     = 1'b0;
    d_stall     = 1'b0;
    e_bubble    = 1'b0;
    d_flush     = 1'b0;
    pipe_freeze = 1'b0;
    case (state_q)
      StRun, StMemWait: begin
        if (!dmem_ready && ((state_q == StMemWait) || m_mem_req)) begin
          // Frozen: history holds and a redirect in E is simply re-presented later.
          pipe_freeze = 1'b1;
          state_d     = StMemWait;
        end else begin
          state_d = StRun;
          if (ex_redirect) begin
            d_flush  = 1'b1;
            e_bubble = 1'b1;
            shift_en = 1'b1;
          end else if (d_valid && d_fence && any_write) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
            shift_en = 1'b1;
            state_d  = StDrain;
          end else if (skip_instr) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
            shift_en = 1'b1;
          end else begin
            shift_en = 1'b1;
            shift_in = d_entry;
          end
        end
      end
      StDrain: begin
        shift_en = 1'b1;
        if (any_write) begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          e_bubble = 1'b1;
        end else begin
          // E/M/W are empty: the fence advances this cycle.
          shift_in = d_entry;
          state_d  = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // History shift: new entry enters E, older entries move toward W.
  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d = {hist_q[1], hist_q[0], shift_in};
    end
  end

  // State and history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
    end
  end

  assign prev1_write      = hist_q[0].write;
  assign prev1_write_addr = hist_q[0].addr;
  assign prev1_mem        = hist_q[0].mem;
  assign prev2_write      = hist_q[1].write;
  assign prev2_write_addr = hist_q[1].addr;
  assign prev2_mem        = hist_q[1].mem;
  assign prev3_write      = hist_q[2].write;
  assign prev3_write_addr = hist_q[2].addr;
  assign prev3_mem        = hist_q[2].mem;

`ifdef HAZ_PERF_CNT_EN
  logic                loaduse_hit;
  logic [XLEN_CNT-1:0] cnt_loaduse_q, cnt_memwait_q, cnt_flush_q;

  // A stall that neither enters nor stays in DRAIN can only be a load-use stall.
  assign loaduse_hit = f_stall && (state_q != StDrain) && (state_d != StDrain);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_loaduse_q <= '0;
      cnt_memwait_q <= '0;
      cnt_flush_q   <= '0;
    end else begin
      if (loaduse_hit && !(&cnt_loaduse_q)) cnt_loaduse_q <= cnt_loaduse_q + XLEN_CNT'(1);
      if (pipe_freeze && !(&cnt_memwait_q)) cnt_memwait_q <= cnt_memwait_q + XLEN_CNT'(1);
      if (d_flush && !(&cnt_flush_q))       cnt_flush_q   <= cnt_flush_q + XLEN_CNT'(1);
    end
  end

  assign cnt_loaduse = cnt_loaduse_q;
  assign cnt_memwait = cnt_memwait_q;
  assign cnt_flush   = cnt_flush_q;
`else
  assign cnt_loaduse = '0;
  assign cnt_memwait = '0;
  assign cnt_flush   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, checked against a queue-based behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n, d_valid, d_rd_write, d_is_load, d_fence;
  logic [4:0]   d_rd_addr;
  logic         skip_instr, ex_redirect, m_mem_req, dmem_ready;
  logic         prev1_write, prev2_write, prev3_write;
  logic [4:0]   prev1_write_addr, prev2_write_addr, prev3_write_addr;
  logic         prev1_mem, prev2_mem, prev3_mem;
  logic         f_stall, d_stall, e_bubble, d_flush, pipe_freeze;
  logic [W-1:0] cnt_loaduse, cnt_memwait, cnt_flush;

  pipeline_hazard_ctrl #(.XLEN_CNT(W)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rd_write(d_rd_write),
    .d_rd_addr(d_rd_addr), .d_is_load(d_is_load), .d_fence(d_fence),
    .skip_instr(skip_instr), .ex_redirect(ex_redirect), .m_mem_req(m_mem_req),
    .dmem_ready(dmem_ready),
    .prev1_write(prev1_write), .prev2_write(prev2_write), .prev3_write(prev3_write),
    .prev1_write_addr(prev1_write_addr), .prev2_write_addr(prev2_write_addr),
    .prev3_write_addr(prev3_write_addr),
    .prev1_mem(prev1_mem), .prev2_mem(prev2_mem), .prev3_mem(prev3_mem),
    .f_stall(f_stall), .d_stall(d_stall), .e_bubble(e_bubble), .d_flush(d_flush),
    .pipe_freeze(pipe_freeze),
    .cnt_loaduse(cnt_loaduse), .cnt_memwait(cnt_memwait), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       w;
    bit [4:0] a;
    bit       m;
  } ent_t;

  typedef struct packed {
    logic [4:0]   ctrl;  // {f_stall, d_stall, e_bubble, d_flush, pipe_freeze}
    logic [20:0]  hist;  // {prev1, prev2, prev3}
    logic [3*W-1:0] cnt; // {loaduse, memwait, flush}
  } exp_t;

  // Reference model state.
  ent_t    hist[$];
  string   mode;          // "run", "wait", "drain"
  longint  c_lu, c_mw, c_fl;
  bit      known = 1'b0;
  exp_t    sb[$];

  int      n_checks = 0;
  int      n_fail   = 0;

  localparam longint CMAX = (longint'(1) << W) - 1;

  function automatic longint sat_inc(longint v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // One clock cycle: drive inputs, predict outputs, then advance the model.
  task automatic step(input bit rn, input bit dv, input bit dw, input bit [4:0] rd,
                      input bit ld, input bit fn, input bit sk, input bit rdr,
                      input bit mreq, input bit rdy);
    bit   fs, eb, df, pf, shift, lu;
    ent_t ent, d_ent;
    bit   any_w;
    string nmode;
    exp_t e;
    @(negedge clk);
    rst_n = rn; d_valid = dv; d_rd_write = dw; d_rd_addr = rd; d_is_load = ld;
    d_fence = fn; skip_instr = sk; ex_redirect = rdr; m_mem_req = mreq; dmem_ready = rdy;
    #1;
    fs = 0; eb = 0; df = 0; pf = 0; shift = 0; lu = 0; ent = '0;
    d_ent = '{w: dv && dw && (rd != 0), a: rd, m: ld};
    any_w = 1'b0;
    foreach (hist[i]) any_w |= hist[i].w;
    nmode = mode;
    if (mode == "drain") begin
      shift = 1;
      if (any_w) begin fs = 1; eb = 1; end
      else begin ent = d_ent; nmode = "run"; end
    end else if (!rdy && (mode == "wait" || mreq)) begin
      pf = 1; nmode = "wait";
    end else begin
      nmode = "run";
      shift = 1;
      if (rdr) begin df = 1; eb = 1; end
      else if (dv && fn && any_w) begin fs = 1; eb = 1; nmode = "drain"; end
      else if (sk) begin fs = 1; eb = 1; lu = 1; end
      else ent = d_ent;
    end
    if (known) begin
      e.ctrl = {fs, fs, eb, df, pf};
      e.hist = {hist[0], hist[1], hist[2]};
`ifdef HAZ_PERF_CNT_EN
      e.cnt = {W'(c_lu), W'(c_mw), W'(c_fl)};
`else
      e.cnt = '0;
`endif
      sb.push_back(e);
    end
    @(posedge clk);
    if (!rn) begin
      hist = '{'0, '0, '0};
      mode = "run";
      c_lu = 0; c_mw = 0; c_fl = 0;
      known = 1'b1;
    end else begin
      if (shift) begin
        hist.push_front(ent);
        void'(hist.pop_back());
      end
      mode = nmode;
      if (lu) c_lu = sat_inc(c_lu);
      if (pf) c_mw = sat_inc(c_mw);
      if (df) c_fl = sat_inc(c_fl);
    end
  endtask

  task automatic idle(input bit rn);
    step(rn, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic wr(input bit [4:0] rd, input bit ld);
    step(1, 1, 1, rd, ld, 0, 0, 0, 0, 1);
  endtask

  // Monitor: compare every DUT output cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({f_stall, d_stall, e_bubble, d_flush, pipe_freeze} !== e.ctrl) begin
          n_fail++;
          $display("FAIL ctrl @%0t: got %b expected %b", $time,
                   {f_stall, d_stall, e_bubble, d_flush, pipe_freeze}, e.ctrl);
        end
        n_checks++;
        if ({prev1_write, prev1_write_addr, prev1_mem, prev2_write, prev2_write_addr,
             prev2_mem, prev3_write, prev3_write_addr, prev3_mem} !== e.hist) begin
          n_fail++;
          $display("FAIL hist @%0t: got %h expected %h", $time,
                   {prev1_write, prev1_write_addr, prev1_mem, prev2_write, prev2_write_addr,
                    prev2_mem, prev3_write, prev3_write_addr, prev3_mem}, e.hist);
        end
        n_checks++;
        if ({cnt_loaduse, cnt_memwait, cnt_flush} !== e.cnt) begin
          n_fail++;
          $display("FAIL cnt @%0t: got %h expected %h", $time,
                   {cnt_loaduse, cnt_memwait, cnt_flush}, e.cnt);
        end
      end
    end
  end

  initial begin
    hist = '{'0, '0, '0};
    mode = "run";
    c_lu = 0; c_mw = 0; c_fl = 0;
    rst_n = 0; d_valid = 0; d_rd_write = 0; d_rd_addr = 0; d_is_load = 0;
    d_fence = 0; skip_instr = 0; ex_redirect = 0; m_mem_req = 0; dmem_ready = 1;

    idle(0);
    idle(0);
    idle(1);

    // Load-use: load to x5, consumer stalls one cycle.
    wr(5'd5, 1);
    step(1, 1, 1, 5'd6, 0, 0, 1, 0, 0, 1);
    wr(5'd6, 0);
    idle(1);

    // Memory wait of three cycles.
    wr(5'd7, 0);
    repeat (3) step(1, 1, 1, 5'd8, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 5'd8, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Redirect and load-use together: redirect wins.
    wr(5'd9, 1);
    step(1, 1, 1, 5'd10, 0, 0, 1, 1, 0, 1);
    idle(1);

    // Fence behind writers to x1/x2/x3.
    wr(5'd1, 0);
    wr(5'd2, 0);
    wr(5'd3, 0);
    repeat (4) step(1, 1, 0, 5'd0, 0, 1, 0, 0, 0, 1);
    idle(1);

    // Reset in the middle of a memory wait.
    wr(5'd4, 1);
    step(1, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // Write to x0 is not recorded as a writer.
    step(1, 1, 1, 5'd0, 1, 0, 0, 0, 0, 1);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 70,
           5'($urandom_range(0, 31)),
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 55);
    end

    idle(1);
    repeat (2) @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
